// File: rtl/cmp_stream_pkg.sv
// Shared types for the lane-parallel relational compare stream.
// Relation codes, their {y,z} mapping, and the skid-buffer state encodings.
package cmp_stream_pkg;

  typedef enum logic [1:0] {
    REL_GT,
    REL_LT,
    REL_EQ
  } rel_e;

  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_FULL  = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = BUF_EMPTY,
    StOne   = BUF_ONE,
    StFull  = BUF_FULL
  } buf_state_e;

  // {y,z}: gt=10, lt=01, eq=11; 00 is never produced.
  function automatic logic [1:0] rel_to_yz(rel_e r);
    case (r)
      REL_GT:  rel_to_yz = 2'b10;
      REL_LT:  rel_to_yz = 2'b01;
      default: rel_to_yz = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/cmp_lane.sv
// Combinational single-lane compare of two WIDTH-bit operands.
// Signed mode flips both sign bits so one unsigned compare covers both cases.
module cmp_lane
  import cmp_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output rel_e             rel_o
);

  logic [WIDTH-1:0] a_adj;
  logic [WIDTH-1:0] b_adj;

  always_comb begin
    a_adj = a_i;
    b_adj = b_i;
    if (signed_mode_i) begin
      a_adj[WIDTH-1] = ~a_i[WIDTH-1];
      b_adj[WIDTH-1] = ~b_i[WIDTH-1];
    end
    if (a_adj > b_adj) begin
      rel_o = REL_GT;
    end else if (a_adj < b_adj) begin
      rel_o = REL_LT;
    end else begin
      rel_o = REL_EQ;
    end
  end

endmodule

// File: rtl/cmp_stream_lanes.sv
// Pipelined multi-lane compare with per-lane saturating "a greater" streaks,
// valid/ready on both sides and a 2-entry output skid buffer.
module cmp_stream_lanes
  import cmp_stream_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_signed,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_y,
  output logic [LANES-1:0]       out_z,
  output logic [LANES*CNT_W-1:0] out_streak,
  input  logic                   clr_streak
);

  rel_e                   rel [LANES];
  logic [LANES-1:0]       new_y;
  logic [LANES-1:0]       new_z;
  logic [LANES*CNT_W-1:0] cnt_q;
  logic [LANES*CNT_W-1:0] cnt_d;
  logic                   acc;
  logic                   con;
  logic                   rst_done_q;
  buf_state_e             state_q;
  logic [LANES-1:0]       y1_q;
  logic [LANES-1:0]       z1_q;
  logic [LANES*CNT_W-1:0] s1_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cmp_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a_i          (in_a[i*WIDTH +: WIDTH]),
      .b_i          (in_b[i*WIDTH +: WIDTH]),
      .signed_mode_i(mode_signed),
      .rel_o        (rel[i])
    );
  end

  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;

  // cnt_d doubles as the streak stored with an accepted beat (post-update value).
  always_comb begin
    new_y = '0;
    new_z = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < LANES; i++) begin
      {new_y[i], new_z[i]} = rel_to_yz(rel[i]);
      if (clr_streak) begin
        cnt_d[i*CNT_W +: CNT_W] = '0;
      end else if (acc) begin
        if (rel[i] != REL_GT) begin
          cnt_d[i*CNT_W +: CNT_W] = '0;
        end else if (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
          cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  // Head entry drives out_* directly; slot 1 holds the second queued result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      rst_done_q <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_z      <= '0;
      out_streak <= '0;
      y1_q       <= '0;
      z1_q       <= '0;
      s1_q       <= '0;
      cnt_q      <= '0;
    end else begin
      rst_done_q <= 1'b1;
      cnt_q      <= cnt_d;
      // rst_done_q holds in_ready low for the first edge after reset release.
      in_ready   <= rst_done_q;
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            out_y      <= new_y;
            out_z      <= new_z;
            out_streak <= cnt_d;
            out_valid  <= 1'b1;
            state_q    <= StOne;
          end
        end
        StOne: begin
          if (acc && !con) begin
            y1_q     <= new_y;
            z1_q     <= new_z;
            s1_q     <= cnt_d;
            in_ready <= 1'b0;
            state_q  <= StFull;
          end else if (acc && con) begin
            out_y      <= new_y;
            out_z      <= new_z;
            out_streak <= cnt_d;
          end else if (con) begin
            out_valid <= 1'b0;
            state_q   <= StEmpty;
          end
        end
        StFull: begin
          if (con) begin
            out_y      <= y1_q;
            out_z      <= z1_q;
            out_streak <= s1_q;
            if (acc) begin
              y1_q     <= new_y;
              z1_q     <= new_z;
              s1_q     <= cnt_d;
              in_ready <= 1'b0;
            end else begin
              state_q <= StOne;
            end
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state_q   <= StEmpty;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_stream_lanes.sv
// Scoreboard bench for cmp_stream_lanes: driver pushes model results, monitor pops on output.
module tb_cmp_stream_lanes;

  localparam int L = 4;
  localparam int W = 8;
  localparam int C = 4;
  localparam int SAT = (1 << C) - 1;

  typedef struct {
    logic [L-1:0]   y;
    logic [L-1:0]   z;
    logic [L*C-1:0] s;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mode_signed = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L*W-1:0] in_a = '0;
  logic [L*W-1:0] in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [L-1:0]   out_y;
  logic [L-1:0]   out_z;
  logic [L*C-1:0] out_streak;
  logic           clr_streak = 1'b0;

  exp_t q[$];
  exp_t e;
  int   streak[L];
  int   passed = 0;
  int   total = 0;
  int   pushed = 0;
  int   popped = 0;
  int   ready_mode = 1;  // 0 hold low, 1 hold high, 2 random

  cmp_stream_lanes #(
    .LANES(L),
    .WIDTH(W),
    .CNT_W(C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_signed(mode_signed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_z      (out_z),
    .out_streak (out_streak),
    .clr_streak (clr_streak)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else                 out_ready = (ready_mode == 1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  function automatic int val(input int unsigned v, input bit sgn);
    if (sgn && v >= (1 << (W - 1))) return int'(v) - (1 << W);
    return int'(v);
  endfunction

  // Reference: relation from integer values, streak as a plain saturating count.
  function automatic exp_t model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                 input bit sgn, input bit clr);
    exp_t r;
    for (int i = 0; i < L; i++) begin
      int av = val(int'(a[i*W +: W]), sgn);
      int bv = val(int'(b[i*W +: W]), sgn);
      r.y[i] = (av >= bv);
      r.z[i] = (av <= bv);
      if (clr || av <= bv) streak[i] = 0;
      else if (streak[i] < SAT) streak[i] = streak[i] + 1;
      r.s[i*C +: C] = C'(streak[i]);
    end
    return r;
  endfunction

  task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input bit sgn,
                      input bit clr);
    in_a = a;
    in_b = b;
    mode_signed = sgn;
    clr_streak = clr;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(a, b, sgn, clr));
        pushed++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_streak = 1'b0;
        return;
      end
    end
    total++;
    $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
    in_valid = 1'b0;
    clr_streak = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got result y=%0h, required none queued", out_y);
      end else begin
        e = q.pop_front();
        popped++;
        check("out_y", 64'(out_y), 64'(e.y));
        check("out_z", 64'(out_z), 64'(e.z));
        check("out_streak", 64'(out_streak), 64'(e.s));
      end
    end
  end

  task automatic rand_lanes(output logic [L*W-1:0] a, output logic [L*W-1:0] b);
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = W'($urandom);
      b[i*W +: W] = ($urandom_range(0, 3) == 0) ? a[i*W +: W] : W'($urandom);
    end
  endtask

  task automatic release_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("in_ready_edge1", 64'(in_ready), 64'd0);
    check("out_valid_edge1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 check("in_ready_edge2", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    for (int i = 0; i < L; i++) streak[i] = 0;

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_z", 64'(out_z), 64'd0);
    check("rst_out_streak", 64'(out_streak), 64'd0);
    @(posedge clk);
    release_reset();

    // Lanes 0..3: a={10,3,7,255}, b={3,10,7,0}
    send({8'd255, 8'd7, 8'd3, 8'd10}, {8'd0, 8'd7, 8'd10, 8'd3}, 1'b0, 1'b0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_y", 64'(out_y), 64'b1101);
    check("first_z", 64'(out_z), 64'b0110);
    check("first_streak", 64'(out_streak), 64'h1001);

    send({24'd0, 8'h80}, {24'd0, 8'h01}, 1'b1, 1'b0);
    check("signed_lane0_yz", 64'({out_y[0], out_z[0]}), 64'b01);
    send({24'd0, 8'h80}, {24'd0, 8'h01}, 1'b0, 1'b0);
    check("unsigned_lane0_yz", 64'({out_y[0], out_z[0]}), 64'b10);

    // Backpressure: two beats fill the buffer, the third waits for a consume.
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rand_lanes(a, b);
    send(a, b, 1'b0, 1'b0);
    rand_lanes(a, b);
    send(a, b, 1'b1, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    fork
      begin
        rand_lanes(a, b);
        send(a, b, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        check("held_in_ready", 64'(in_ready), 64'd0);
        check("held_pushed", 64'(pushed), 64'd5);
        ready_mode = 1;
      end
    join

    // Saturation on lane 0, then an eq beat.
    for (int n = 0; n < 20; n++) begin
      rand_lanes(a, b);
      a[W-1:0] = 8'd200;
      b[W-1:0] = 8'd1;
      send(a, b, 1'b0, 1'b0);
      if (n >= 15) check("sat_lane0", 64'(out_streak[C-1:0]), 64'(SAT));
    end
    rand_lanes(a, b);
    b[W-1:0] = a[W-1:0];
    send(a, b, 1'b0, 1'b0);

    // Streak of 5, then clear alongside a gt beat, then one more gt.
    for (int n = 0; n < 7; n++) begin
      rand_lanes(a, b);
      a[W-1:0] = 8'd9;
      b[W-1:0] = 8'd4;
      send(a, b, 1'b0, n == 5);
      if (n == 5) check("clr_lane0", 64'(out_streak[C-1:0]), 64'd0);
      if (n == 6) check("after_clr_lane0", 64'(out_streak[C-1:0]), 64'd1);
    end

    // Async reset while full with a third beat presented.
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    rand_lanes(a, b);
    send(a, b, 1'b0, 1'b0);
    rand_lanes(a, b);
    send(a, b, 1'b0, 1'b0);
    rand_lanes(a, b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_out_yz", 64'({out_y, out_z}), 64'd0);
    check("async_out_streak", 64'(out_streak), 64'd0);
    q.delete();
    pushed = 0;
    popped = 0;
    for (int i = 0; i < L; i++) streak[i] = 0;
    in_valid = 1'b0;
    ready_mode = 1;
    @(posedge clk);
    release_reset();
    check("no_stale_valid", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure and occasional clears.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      rand_lanes(a, b);
      send(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    ready_mode = 1;
    for (int n = 0; n < 500 && q.size() != 0; n++) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    check("pushed_vs_popped", 64'(popped), 64'(pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
